// File: rtl/keypad_calc_sequencer.sv
// ---------------------------------------------------------------------------
// keypad_calc_sequencer
//
// Purpose:
//   Control FSM sitting between the keypad scanner and the 4x4 multiplier.
//   Synchronizes and debounces the raw key_down level into single-cycle key
//   events, assembles two decimal operands (0..15), starts the multiplier and
//   shows the product on the LEDs. Everything runs on CLOCK_50.
//
// Ports:
//   CLOCK_50      in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   key_down      in   raw "any key pressed" level, asynchronous
//   key_code[3:0] in   0-9 digit, 10 next (*), 11 clear (#), others invalid
//   mult_done     in   multiplier result-valid strobe
//   mult_result   in   product, valid with mult_done
//   op_a[3:0]     out  operand A
//   op_b[3:0]     out  operand B
//   mult_start    out  one-cycle start pulse
//   led[7:0]      out  display value
//   busy          out  high in START and WAIT
//   err           out  sticky error flag
//   o_dbg_state   out  current FSM state (0 ENTER_A, 1 ENTER_B, 2 START,
//                      3 WAIT, 4 SHOW, 5 ERROR)
//   o_dbg_key_evt out  debounced key event (one cycle per accepted press)
//
// Handshake: mult_start is high for exactly one cycle (the START state); the
//   operands are stable from START until SHOW is left. The multiplier answers
//   with a one-cycle mult_done carrying mult_result; it is only accepted in
//   WAIT and wins over a simultaneous key event or timeout.
//
// Optional feature: define KCS_TIMEOUT_EN to build a WAIT watchdog that moves
//   to ERROR after TIMEOUT_CYCLES WAIT cycles without mult_done.
// ---------------------------------------------------------------------------
module keypad_calc_sequencer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
`ifdef KCS_TIMEOUT_EN
  ,
  parameter logic [7:0]  TIMEOUT_CYCLES  = 8'd64
`endif
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       key_down,
  input  logic [3:0] key_code,
  input  logic       mult_done,
  input  logic [7:0] mult_result,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       mult_start,
  output logic [7:0] led,
  output logic       busy,
  output logic       err,
  output logic [2:0] o_dbg_state,
  output logic       o_dbg_key_evt
);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_SHOW    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // ------------------------------------------------------------------------
  // Synchronizer and debouncer
  // ------------------------------------------------------------------------
  logic        r_sync1;
  logic        r_sync2;
  logic        r_armed;
  logic [15:0] r_db_cnt;
  logic        w_db_full;
  logic        w_key_evt;

  assign w_db_full = (r_db_cnt == DEBOUNCE_CYCLES - 16'd1);
  // The press event is the cycle carrying the last needed high sample.
  assign w_key_evt = r_armed & r_sync2 & w_db_full;

  // While armed we count high samples (waiting for a press); once disarmed we
  // count low samples (waiting for a release). Any opposite sample restarts.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_armed  <= 1'b1;
      r_db_cnt <= 16'd0;
    end else begin
      r_sync1 <= key_down;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_armed) begin
        if (w_db_full) begin
          r_armed  <= ~r_armed;
          r_db_cnt <= 16'd0;
        end else begin
          r_db_cnt <= r_db_cnt + 16'd1;
        end
      end else begin
        r_db_cnt <= 16'd0;
      end
    end
  end

  // ------------------------------------------------------------------------
  // WAIT watchdog
  // ------------------------------------------------------------------------
  logic w_timeout;
`ifdef KCS_TIMEOUT_EN
  logic [7:0] r_to_cnt;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= 8'd0;
    end else if (r_state == S_START) begin
      r_to_cnt <= 8'd0;
    end else if (r_state == S_WAIT) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_to_cnt == TIMEOUT_CYCLES - 8'd1);
`else
  assign w_timeout = 1'b0;
`endif

  // ------------------------------------------------------------------------
  // Key decode and operand arithmetic
  // ------------------------------------------------------------------------
  logic       w_is_digit;
  logic       w_is_next;
  logic       w_is_clear;
  logic [3:0] w_cur_op;
  logic [7:0] w_cand;
  logic       w_cand_ok;

  assign w_is_digit = (key_code <= 4'd9);
  assign w_is_next  = (key_code == 4'd10);
  assign w_is_clear = (key_code == 4'd11);
  assign w_cur_op   = (r_state == S_ENTER_B) ? op_b : op_a;
  // 8 bits is enough: 15*10 + 9 = 159.
  assign w_cand     = ({4'd0, w_cur_op} * 8'd10) + {4'd0, key_code};
  assign w_cand_ok  = (w_cand <= 8'd15);

  // ------------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_ENTER_A;
      mult_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      mult_start <= (w_next_state == S_START);
      busy       <= (w_next_state == S_START) || (w_next_state == S_WAIT);
    end
  end

  // ------------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_ENTER_A: if (w_key_evt && w_is_next) w_next_state = S_ENTER_B;
      S_ENTER_B: begin
        if (w_key_evt && w_is_next)       w_next_state = S_START;
        else if (w_key_evt && w_is_clear) w_next_state = S_ENTER_A;
      end
      S_START:   w_next_state = S_WAIT;
      S_WAIT: begin
        if (mult_done)      w_next_state = S_SHOW;
        else if (w_timeout) w_next_state = S_ERROR;
      end
      S_SHOW, S_ERROR: if (w_key_evt && w_is_clear) w_next_state = S_ENTER_A;
      default:   w_next_state = S_ENTER_A;
    endcase
  end

  // ------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // ------------------------------------------------------------------------
  logic [3:0] w_op_a_nxt;
  logic [3:0] w_op_b_nxt;
  logic [7:0] w_led_nxt;
  logic       w_err_nxt;

  always_comb begin
    w_op_a_nxt = op_a;
    w_op_b_nxt = op_b;
    w_led_nxt  = led;
    w_err_nxt  = err;
    case (r_state)
      S_ENTER_A, S_ENTER_B: begin
        if (w_key_evt) begin
          if (w_is_clear) begin
            w_op_a_nxt = 4'd0;
            w_op_b_nxt = 4'd0;
            w_err_nxt  = 1'b0;
          end else if (w_is_digit) begin
            if (!w_cand_ok)                w_err_nxt  = 1'b1;
            else if (r_state == S_ENTER_A) w_op_a_nxt = w_cand[3:0];
            else                           w_op_b_nxt = w_cand[3:0];
          end
        end
        w_led_nxt = {w_op_a_nxt, w_op_b_nxt};
      end
      S_WAIT: begin
        if (mult_done) begin
          w_led_nxt = mult_result;
        end else if (w_timeout) begin
          w_led_nxt = 8'hFF;
          w_err_nxt = 1'b1;
        end
      end
      S_SHOW, S_ERROR: begin
        if (w_key_evt && w_is_clear) begin
          w_op_a_nxt = 4'd0;
          w_op_b_nxt = 4'd0;
          w_led_nxt  = 8'd0;
          w_err_nxt  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= 4'd0;
      op_b <= 4'd0;
      led  <= 8'd0;
      err  <= 1'b0;
    end else begin
      op_a <= w_op_a_nxt;
      op_b <= w_op_b_nxt;
      led  <= w_led_nxt;
      err  <= w_err_nxt;
    end
  end

  assign o_dbg_state   = r_state;
  assign o_dbg_key_evt = w_key_evt;

endmodule

// File: tb/tb_keypad_calc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_keypad_calc_sequencer
//
// Self-checking bench for keypad_calc_sequencer with DEBOUNCE_CYCLES = 4.
// Expected products are pushed to exp_q when operands are keyed in and popped
// when the DUT reaches SHOW. Define KCS_TIMEOUT_EN to exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_keypad_calc_sequencer;

  localparam logic [2:0] ST_ENTER_A = 3'd0;
  localparam logic [2:0] ST_ENTER_B = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_SHOW    = 3'd4;
`ifdef KCS_TIMEOUT_EN
  localparam logic [2:0] ST_ERROR   = 3'd5;
`endif

  localparam logic [3:0] K_NEXT  = 4'd10;
  localparam logic [3:0] K_CLEAR = 4'd11;

  // ---------------- clock / reset ----------------
  logic       CLOCK_50 = 1'b0;
  logic       rst_n    = 1'b0;
  logic       key_down = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       man_done = 1'b0;
  logic [7:0] man_res  = 8'd0;
  logic       mdl_done = 1'b0;
  logic [7:0] mdl_res  = 8'd0;
  logic       mdl_en   = 1'b0;
  wire        mult_done;
  wire  [7:0] mult_result;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       mult_start;
  logic [7:0] led;
  logic       busy;
  logic       err;
  logic [2:0] dbg_state;
  logic       dbg_key_evt;

  assign mult_done   = mdl_done | man_done;
  assign mult_result = mdl_done ? mdl_res : man_res;

  always #5 CLOCK_50 = ~CLOCK_50;

  keypad_calc_sequencer #(
    .DEBOUNCE_CYCLES(16'd4)
`ifdef KCS_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8'd8)
`endif
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .rst_n        (rst_n),
    .key_down     (key_down),
    .key_code     (key_code),
    .mult_done    (mult_done),
    .mult_result  (mult_result),
    .op_a         (op_a),
    .op_b         (op_b),
    .mult_start   (mult_start),
    .led          (led),
    .busy         (busy),
    .err          (err),
    .o_dbg_state  (dbg_state),
    .o_dbg_key_evt(dbg_key_evt)
  );

  // ---------------- multiplier model: done 3 cycles after start ----------------
  int start_cnt = 0;
  int evt_cnt   = 0;
  int mdl_delay = 0;

  always @(negedge CLOCK_50) begin
    mdl_done = 1'b0;
    if (mult_start) begin
      start_cnt++;
      if (mdl_en) mdl_delay = 3;
    end else if (mdl_delay != 0) begin
      mdl_delay--;
      if (mdl_delay == 0) begin
        mdl_done = 1'b1;
        mdl_res  = {4'd0, op_a} * {4'd0, op_b};
      end
    end
    if (rst_n && dbg_key_evt) evt_cnt++;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic press(input logic [3:0] code);
    @(negedge CLOCK_50);
    key_code = code;
    key_down = 1'b1;
    repeat (8) @(negedge CLOCK_50);
    key_down = 1'b0;
    repeat (8) @(negedge CLOCK_50);
  endtask

  task automatic hold_level(input logic lvl, input int cycles);
    @(negedge CLOCK_50);
    key_down = lvl;
    repeat (cycles - 1) @(negedge CLOCK_50);
  endtask

  task automatic pulse_done(input logic [7:0] res);
    @(negedge CLOCK_50);
    man_done = 1'b1;
    man_res  = res;
    @(negedge CLOCK_50);
    man_done = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int max_cyc);
    int n;
    n = 0;
    while (dbg_state != s && n < max_cyc) begin
      @(negedge CLOCK_50);
      n++;
    end
    check(tag, dbg_state, s);
  endtask

  task automatic wait_show(input string tag);
    logic [7:0] exp;
    wait_state({tag, "_reach_show"}, ST_SHOW, 100);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_led"}, led, exp);
    end
  endtask

  task automatic enter_pair(input logic [3:0] a, input logic [3:0] b);
    press(a);
    press(K_NEXT);
    press(b);
    press(K_NEXT);
  endtask

  // ---------------- global watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int s0;
    int e0;
    int found;
    int wcnt;

    // Reset state
    #1;
    check("rst_led", led, 8'd0);
    check("rst_op_a", op_a, 4'd0);
    check("rst_op_b", op_b, 4'd0);
    check("rst_start", mult_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_state", dbg_state, ST_ENTER_A);
    repeat (3) @(negedge CLOCK_50);
    rst_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // Basic multiply 3 * 5
    mdl_en = 1'b1;
    s0 = start_cnt;
    exp_q.push_back(8'(3 * 5));
    enter_pair(4'd3, 4'd5);
    wait_show("basic");
    check("basic_op_a", op_a, 4'd3);
    check("basic_op_b", op_b, 4'd5);
    check("basic_busy", busy, 1'b0);
    check("basic_starts", start_cnt - s0, 1);
    press(K_CLEAR);
    check("basic_clr_state", dbg_state, ST_ENTER_A);
    check("basic_clr_led", led, 8'd0);

    // Two-digit entry and overflow
    press(4'd1);
    press(4'd2);
    check("ovf_op_a12", op_a, 4'd12);
    check("ovf_led12", led, 8'hC0);
    press(4'd7);
    check("ovf_op_a_hold", op_a, 4'd12);
    check("ovf_err", err, 1'b1);
    press(K_CLEAR);
    check("ovf_clr_err", err, 1'b0);
    check("ovf_clr_op_a", op_a, 4'd0);
    press(4'd1);
    press(4'd5);
    press(K_NEXT);
    check("ovf_state_b", dbg_state, ST_ENTER_B);
    exp_q.push_back(8'(15 * 15));
    press(4'd1);
    press(4'd5);
    press(K_NEXT);
    wait_show("ovf15x15");
    check("ovf_err_final", err, 1'b0);
    press(K_CLEAR);

    // Debounce
    key_code = 4'd1;
    e0 = evt_cnt;
    hold_level(1'b1, 3);
    hold_level(1'b0, 10);
    check("db_glitch_evts", evt_cnt - e0, 0);
    check("db_glitch_op_a", op_a, 4'd0);
    hold_level(1'b1, 200);
    check("db_hold_evts", evt_cnt - e0, 1);
    check("db_hold_op_a", op_a, 4'd1);
    hold_level(1'b0, 2);
    hold_level(1'b1, 10);
    check("db_short_rel_evts", evt_cnt - e0, 1);
    hold_level(1'b0, 4);
    hold_level(1'b1, 10);
    check("db_rearm_evts", evt_cnt - e0, 2);
    check("db_rearm_op_a", op_a, 4'd11);
    hold_level(1'b0, 10);
    press(K_CLEAR);

    // Handshake corners
    pulse_done(8'h5A);
    repeat (2) @(negedge CLOCK_50);
    check("hs_done_idle_state", dbg_state, ST_ENTER_A);
    check("hs_done_idle_led", led, 8'd0);
    mdl_en = 1'b0;
    enter_pair(4'd2, 4'd3);
    wait_state("hs_reach_wait", ST_WAIT, 40);
    check("hs_wait_busy", busy, 1'b1);
    e0 = evt_cnt;
    press(4'd4);
    check("hs_wait_key_evt", evt_cnt - e0, 1);
    check("hs_wait_state", dbg_state, ST_WAIT);
    check("hs_wait_op_a", op_a, 4'd2);
    check("hs_wait_op_b", op_b, 4'd3);
    // mult_done in the very cycle of a key event
    @(negedge CLOCK_50);
    key_code = 4'd7;
    key_down = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge CLOCK_50);
      if (dbg_key_evt) found = 1;
    end
    check("hs_coinc_evt_seen", found, 1);
    exp_q.push_back(8'(2 * 3));
    man_done = 1'b1;
    man_res  = 8'(2 * 3);
    @(negedge CLOCK_50);
    man_done = 1'b0;
    key_down = 1'b0;
    wait_show("hs_coinc");
    repeat (8) @(negedge CLOCK_50);
    press(K_CLEAR);

    // Reset asserted in WAIT
    enter_pair(4'd4, 4'd2);
    wait_state("rw_reach_wait", ST_WAIT, 40);
    @(negedge CLOCK_50);
    #2 rst_n = 1'b0;
    #1;
    check("rw_state", dbg_state, ST_ENTER_A);
    check("rw_busy", busy, 1'b0);
    check("rw_start", mult_start, 1'b0);
    check("rw_op_a", op_a, 4'd0);
    check("rw_op_b", op_b, 4'd0);
    check("rw_led", led, 8'd0);
    check("rw_err", err, 1'b0);
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    pulse_done(8'd8);
    repeat (2) @(negedge CLOCK_50);
    check("rw_stale_state", dbg_state, ST_ENTER_A);
    check("rw_stale_led", led, 8'd0);

    // WAIT watchdog / indefinite wait
    enter_pair(4'd1, 4'd1);
`ifdef KCS_TIMEOUT_EN
    // enter_pair ends long after WAIT would have timed out, so redo START
    // from a fresh entry with explicit cycle counting.
    wait_state("to_reach_error1", ST_ERROR, 40);
    press(K_CLEAR);
    press(4'd1);
    press(K_NEXT);
    press(4'd1);
    @(negedge CLOCK_50);
    key_code = K_NEXT;
    key_down = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge CLOCK_50);
      if (dbg_state == ST_WAIT) found = 1;
    end
    check("to_reach_wait", found, 1);
    wcnt = 0;
    for (int i = 0; i < 40 && dbg_state == ST_WAIT; i++) begin
      wcnt++;
      @(negedge CLOCK_50);
    end
    key_down = 1'b0;
    check("to_wait_cycles", wcnt, 8);
    check("to_state", dbg_state, ST_ERROR);
    check("to_led", led, 8'hFF);
    check("to_err", err, 1'b1);
    repeat (8) @(negedge CLOCK_50);
    press(K_CLEAR);
    check("to_clr_state", dbg_state, ST_ENTER_A);
    check("to_clr_led", led, 8'd0);
    check("to_clr_err", err, 1'b0);
`else
    wait_state("nt_reach_wait", ST_WAIT, 40);
    wcnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLOCK_50);
      if (dbg_state == ST_WAIT) wcnt++;
    end
    check("nt_wait_1000", wcnt, 1000);
    check("nt_busy", busy, 1'b1);
    exp_q.push_back(8'(1 * 1));
    pulse_done(8'(1 * 1));
    wait_show("nt_late_done");
    press(K_CLEAR);
    check("nt_clr_state", dbg_state, ST_ENTER_A);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
